// File: rtl/robot_motion.sv
// robot_motion: turns front/turn decisions into timed motor actions with a settle pause and move counters
module robot_motion #(
  parameter int FWD_CYCLES   = 8,
  parameter int TURN_CYCLES  = 12,
  parameter int PAUSE_CYCLES = 2,
  parameter int CW           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       front,
  input  logic       turn,
  output logic       mot_l_fwd,
  output logic       mot_l_rev,
  output logic       mot_r_fwd,
  output logic       mot_r_rev,
  output logic       busy,
  output logic       step_done,
  output logic [7:0] fwd_moves,
  output logic [7:0] turns
);
  typedef enum logic [1:0] {IDLE, FORWARD, TURN, SETTLE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic last;
  assign last = cnt == '0;
  assign mot_l_fwd = state == FORWARD || state == TURN;
  assign mot_l_rev = 1'b0;
  assign mot_r_fwd = state == FORWARD;
  assign mot_r_rev = state == TURN;
  assign busy = state != IDLE;
  // next state and duration reload; commands are only looked at in IDLE, turn wins
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: begin
        state_n = turn ? TURN : front ? FORWARD : IDLE;
        cnt_n = turn ? CW'(TURN_CYCLES - 1) : front ? CW'(FWD_CYCLES - 1) : cnt;
      end
      FORWARD, TURN: begin
        state_n = last ? SETTLE : state;
        cnt_n = last ? CW'(PAUSE_CYCLES - 1) : cnt - CW'(1);
      end
      default: begin
        state_n = last ? IDLE : SETTLE;
        cnt_n = last ? cnt : cnt - CW'(1);
      end
    endcase
  end
  // state, duration counter, completion strobe and wrap-around move counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      step_done <= 1'b0;
      fwd_moves <= '0;
      turns <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      step_done <= state == SETTLE && last;
      fwd_moves <= fwd_moves + 8'(state == FORWARD && last);
      turns <= turns + 8'(state == TURN && last);
    end
  end
endmodule

// File: tb/tb_robot_motion.sv
// tb_robot_motion: randomized scoreboard bench for robot_motion against a timeline reference model
module tb_robot_motion;
  localparam int FC = 8;
  localparam int TC = 12;
  localparam int PC = 2;

  logic clk, reset, front, turn;
  logic mot_l_fwd, mot_l_rev, mot_r_fwd, mot_r_rev, busy, step_done;
  logic [7:0] fwd_moves, turns;

  typedef struct {
    bit t;
    int acc;
    int fwd;
    int trn;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int edges = 0;
  int free_at = 0;
  int mf = 0;
  int mt = 0;
  bit rst_prev = 0;
  bit armed = 0;
  logic eb, ed;
  logic [3:0] ep;
  int n;

  robot_motion #(.FWD_CYCLES(FC), .TURN_CYCLES(TC), .PAUSE_CYCLES(PC), .CW(8)) dut (
    .clk(clk), .reset(reset), .front(front), .turn(turn),
    .mot_l_fwd(mot_l_fwd), .mot_l_rev(mot_l_rev), .mot_r_fwd(mot_r_fwd), .mot_r_rev(mot_r_rev),
    .busy(busy), .step_done(step_done), .fwd_moves(fwd_moves), .turns(turns)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edges);
    end
  endtask

  // drive one edge worth of inputs and let the model decide whether a command is accepted
  task automatic cyc(input logic f, input logic t, input logic r);
    int e;
    exp_t x;
    @(negedge clk);
    if (rst_prev) begin
      chk("rst_fwd_moves", 32'(fwd_moves), 0);
      chk("rst_turns", 32'(turns), 0);
    end
    rst_prev = r;
    front = f;
    turn = t;
    reset = r;
    e = edges + 1;
    if (r) begin
      q.delete();
      mf = 0;
      mt = 0;
      free_at = e + 1;
    end else if (e >= free_at && (f || t)) begin
      mt = t ? (mt + 1) % 256 : mt;
      mf = t ? mf : (mf + 1) % 256;
      x.t = t;
      x.acc = e;
      x.fwd = mf;
      x.trn = mt;
      q.push_back(x);
      free_at = e + (t ? TC : FC) + PC + 1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && q.size() != 0; i++) cyc(0, 0, 0);
    chk("drain_empty", 32'(q.size()), 0);
  endtask

  // monitor: expected outputs each cycle follow from the head action's acceptance edge
  always begin
    @(posedge clk);
    #1;
    if (reset) armed = 1;
    if (armed) begin
      eb = 0;
      ep = 4'b0000;
      ed = 0;
      if (q.size() > 0 && edges >= q[0].acc) begin
        n = q[0].t ? TC : FC;
        eb = edges < q[0].acc + n + PC;
        ep = edges < q[0].acc + n ? (q[0].t ? 4'b1001 : 4'b1010) : 4'b0000;
        ed = edges == q[0].acc + n + PC;
      end
      chk("motors", 32'({mot_l_fwd, mot_l_rev, mot_r_fwd, mot_r_rev}), 32'(ep));
      chk("busy", 32'(busy), 32'(eb));
      chk("step_done", 32'(step_done), 32'(ed));
      if (ed) begin
        chk("fwd_moves", 32'(fwd_moves), q[0].fwd);
        chk("turns", 32'(turns), q[0].trn);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    reset = 1;
    front = 0;
    turn = 0;
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    drain();
    cyc(0, 1, 0);
    drain();
    cyc(1, 1, 0);
    for (int i = 0; i < 13; i++) cyc(i[0], 0, 0);
    drain();
    for (int i = 0; i < 20; i++) cyc(0, 0, 0);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
    drain();
    cyc(1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    cyc(0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0);
    for (int i = 0; i < 257 * 11; i++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    drain();
    chk("wrap_fwd_moves", 32'(fwd_moves), 1);
    chk("wrap_turns", 32'(turns), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
